pid_pipe: RTL



---
 rtl/pid_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pid_pipe.sv
// Three-stage pipelined PID balance controller with soft-start timer.
// Optional soft-start output clamp: define PID_SS_CLAMP_EN.
module pid_pipe #(
    parameter int IN_W    = 16,
    parameter int ERR_W   = 10,
    parameter int OUT_W   = 12,
    parameter int P_COEFF = 9,
    parameter int I_W     = 18,
    parameter int I_SHIFT = 6,
    parameter int D_SHIFT = 6,
    parameter int SS_W    = 8,
    parameter int SS_PRE  = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             pwr_up,
    input  logic             rider_off,
    input  logic [IN_W-1:0]  ptch,
    input  logic [IN_W-1:0]  ptch_rt,
    output logic [SS_W-1:0]  ss_tmr,
    output logic [OUT_W-1:0] PID_cntrl,
    output logic             cntrl_vld
);

    localparam int P_W   = ERR_W + 6;
    localparam int SUM_W = OUT_W + 4;
    localparam int CNT_W = SS_W + SS_PRE;

    localparam logic signed [IN_W-1:0] ERR_MAX = IN_W'(2**(ERR_W-1) - 1);
    localparam logic signed [IN_W-1:0] ERR_MIN = IN_W'(-(2**(ERR_W-1)));
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'(2**(OUT_W-1) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(2**(OUT_W-1)));
    localparam logic signed [P_W-1:0] P_K = P_W'(P_COEFF);

    logic                    v1;
    logic                    v2;
    logic signed [ERR_W-1:0] err1;
    logic signed [IN_W-1:0]  rt1;
    logic signed [P_W-1:0]   p2;
    logic signed [IN_W-1:0]  d2;
    logic signed [I_W-1:0]   integ;
    logic [CNT_W-1:0]        ss_cnt;

    logic signed [ERR_W-1:0] err_sat;
    logic signed [P_W-1:0]   p_nxt;
    logic signed [IN_W-1:0]  d_nxt;
    logic signed [I_W-1:0]   i_add;
    logic signed [I_W-1:0]   i_sum;
    logic                    i_ovf;
    logic signed [I_W-1:0]   i_sh;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] clip;
    logic [OUT_W-1:0]        out_nxt;
`ifdef PID_SS_CLAMP_EN
    localparam int SS_SH = OUT_W - 1 - SS_W;
    logic signed [SUM_W-1:0] lim;
`endif

    assign ss_tmr = ss_cnt[CNT_W-1 -: SS_W];

    always_comb begin
        err_sat = ptch[ERR_W-1:0];
        if ($signed(ptch) > ERR_MAX) begin
            err_sat = ERR_MAX[ERR_W-1:0];
        end else if ($signed(ptch) < ERR_MIN) begin
            err_sat = ERR_MIN[ERR_W-1:0];
        end
    end

    always_comb begin
        p_nxt = P_K * P_W'(err1);
        d_nxt = -(rt1 >>> D_SHIFT);
        i_add = I_W'(err1);
        i_sum = integ + i_add;
        // Same-sign operands producing a flipped sign means wrap-around.
        i_ovf = (integ[I_W-1] == i_add[I_W-1])
             && (i_sum[I_W-1] != integ[I_W-1]);
    end

    always_comb begin
        i_sh = integ >>> I_SHIFT;
        sum  = SUM_W'(p2) + SUM_W'(i_sh) + SUM_W'(d2);
        clip = sum;
        if (sum > OUT_MAX) begin
            clip = OUT_MAX;
        end else if (sum < OUT_MIN) begin
            clip = OUT_MIN;
        end
`ifdef PID_SS_CLAMP_EN
        lim = SUM_W'(ss_tmr) << SS_SH;
        if (lim > OUT_MAX) begin
            lim = OUT_MAX;
        end
        if (clip > lim) begin
            clip = lim;
        end else if (clip < -lim) begin
            clip = -lim;
        end
`endif
        out_nxt = clip[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            err1      <= '0;
            rt1       <= '0;
            p2        <= '0;
            d2        <= '0;
            integ     <= '0;
            ss_cnt    <= '0;
            PID_cntrl <= '0;
            cntrl_vld <= 1'b0;
        end else begin
            v1 <= vld;
            if (vld) begin
                err1 <= err_sat;
                rt1  <= ptch_rt;
            end
            v2 <= v1;
            if (v1) begin
                p2 <= p_nxt;
                d2 <= d_nxt;
            end
            if (rider_off) begin
                integ <= '0;
            end else if (v1 && !i_ovf) begin
                integ <= i_sum;
            end
            cntrl_vld <= v2;
            if (v2) begin
                PID_cntrl <= out_nxt;
            end
            if (!pwr_up) begin
                ss_cnt <= '0;
            end else if (ss_tmr != '1) begin
                ss_cnt <= ss_cnt + CNT_W'(1);
            end
        end
    end

endmodule
